// File: rtl/i2s_tx_stereo.sv
// I2S (Philips) stereo transmitter with fractional BCK/LRCK generation and a one-pair input holding register.
// Latency: a pair accepted before a frame load goes out in that frame, left MSB first, one BCK after the LRCK fall.
// Backpressure: s_ready drops while the holding register is full and rises the clk after the next frame load.
// Optional build macro I2S_TX_TESTGEN_EN adds test_en: frames then carry a counter pattern instead of port data.
module i2s_tx_stereo #(
  parameter int CLK_HZ    = 12000000,
  parameter int SAMPLE_HZ = 44100,
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 16,
  parameter int ACC_W     = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bck,
  output logic              lrck,
  output logic              din,
  output logic              frame_start,
  output logic              underrun
`ifdef I2S_TX_TESTGEN_EN
  ,
  input  logic              test_en
`endif
);

  localparam longint INC_L = longint'(4) * longint'(SAMPLE_HZ) * longint'(SLOT_W);
  localparam int     FW    = 2 * SLOT_W;
  localparam int     PW    = $clog2(FW);
  localparam logic [ACC_W-1:0] INC_A = ACC_W'(INC_L);
  localparam logic [ACC_W-1:0] CLK_A = ACC_W'(longint'(CLK_HZ));

  // Reject configurations the accumulator or slot layout cannot represent.
  if (INC_L > longint'(CLK_HZ)) begin : g_err_rate
    $error("i2s_tx_stereo: bit-clock edge rate exceeds CLK_HZ");
  end
  if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_err_width
    $error("i2s_tx_stereo: DATA_W must be in 1..SLOT_W");
  end
  if ((longint'(CLK_HZ) + INC_L) >= (longint'(1) << ACC_W)) begin : g_err_acc
    $error("i2s_tx_stereo: ACC_W too small for CLK_HZ + INC");
  end

  logic [ACC_W-1:0]  acc, acc_sum;
  logic              tick, fall, load;
  logic [PW-1:0]     pos, pos_nxt;
  logic [FW-1:0]     sh, frame;
  logic              hold_full, hold_full_nxt, hold_clr, hold_fill;
  logic [DATA_W-1:0] hold_l, hold_r, ld_l, ld_r;
  logic              accept, bypass, ld_und, test_mode;
`ifdef I2S_TX_TESTGEN_EN
  logic [DATA_W-1:0] cnt;
  logic              cnt_inc;
  assign test_mode = test_en;
`else
  assign test_mode = 1'b0;
`endif

  // Phase accumulator: one tick per BCK edge, exact long-term rate.
  always_comb begin
    acc_sum = acc + INC_A;
    tick    = (acc_sum >= CLK_A);
    fall    = tick && bck;
    pos_nxt = (pos == PW'(FW - 1)) ? '0 : pos + 1'b1;
    load    = fall && (pos_nxt == PW'(1));
  end

  // Pick the frame source at load time: holding register, bypass, or silence.
  always_comb begin
    ld_l     = '0;
    ld_r     = '0;
    ld_und   = 1'b0;
    hold_clr = 1'b0;
    bypass   = 1'b0;
    accept   = s_valid && s_ready;
`ifdef I2S_TX_TESTGEN_EN
    cnt_inc  = 1'b0;
`endif
    if (load) begin
`ifdef I2S_TX_TESTGEN_EN
      if (test_en) begin
        ld_l    = cnt;
        ld_r    = ~cnt;
        cnt_inc = 1'b1;
      end else
`endif
      if (hold_full) begin
        ld_l     = hold_l;
        ld_r     = hold_r;
        hold_clr = 1'b1;
      end else if (accept) begin
        ld_l   = s_left;
        ld_r   = s_right;
        bypass = 1'b1;
      end else begin
        ld_und = 1'b1;
      end
    end
    hold_fill     = accept && !bypass;
    hold_full_nxt = hold_clr ? 1'b0 : (hold_fill ? 1'b1 : hold_full);
    frame = {SLOT_W'(ld_l) << (SLOT_W - DATA_W), SLOT_W'(ld_r) << (SLOT_W - DATA_W)};
  end

  // Accumulator, bit clock, word select and serial shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      bck         <= 1'b0;
      lrck        <= 1'b1;
      din         <= 1'b0;
      pos         <= PW'(FW - 1);
      sh          <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      acc         <= tick ? acc_sum - CLK_A : acc_sum;
      frame_start <= load;
      underrun    <= ld_und;
      if (tick) bck <= !bck;
      if (fall) begin
        pos  <= pos_nxt;
        lrck <= (pos_nxt >= PW'(SLOT_W));
        if (load) begin
          din <= frame[FW-1];
          sh  <= frame << 1;
        end else begin
          din <= sh[FW-1];
          sh  <= sh << 1;
        end
      end
    end
  end

  // One-pair holding register and its registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      s_ready   <= 1'b1;
    end else begin
      hold_full <= hold_full_nxt;
      s_ready   <= !hold_full_nxt && !test_mode;
      if (hold_fill) begin
        hold_l <= s_left;
        hold_r <= s_right;
      end
    end
  end

`ifdef I2S_TX_TESTGEN_EN
  // Test pattern counter, advanced once per test-mode frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2s_tx_stereo.sv
module tb_i2s_tx_stereo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_left = '0, s_right = '0;
  logic [11:0] p_left = 12'hABC, p_right = 12'h800;
  logic        s_ready, bck, lrck, din, frame_start, underrun;
  logic        p_ready, p_bck, p_lrck, p_din, p_fs, p_ur;
`ifdef I2S_TX_TESTGEN_EN
  logic        test_en = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepted = 0;
  int last_fs  = 0;
  bit have_prev = 0;
  logic [15:0] q_l[$], q_r[$];

  always #5 clk = ~clk;

  i2s_tx_stereo #(.CLK_HZ(12000000), .SAMPLE_HZ(46875), .DATA_W(16), .SLOT_W(16), .ACC_W(25)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .bck(bck), .lrck(lrck), .din(din),
    .frame_start(frame_start), .underrun(underrun)
`ifdef I2S_TX_TESTGEN_EN
    , .test_en(test_en)
`endif
  );

  i2s_tx_stereo #(.CLK_HZ(12000000), .SAMPLE_HZ(46875), .DATA_W(12), .SLOT_W(16), .ACC_W(25)) dut_pad (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(p_ready),
    .s_left(p_left), .s_right(p_right), .bck(p_bck), .lrck(p_lrck), .din(p_din),
    .frame_start(p_fs), .underrun(p_ur)
`ifdef I2S_TX_TESTGEN_EN
    , .test_en(test_en)
`endif
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clk; outputs sampled 1 time unit after the edge; source advances on handshake.
  task automatic step();
    logic rb;
    rb = s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (s_valid && rb && rst_n) begin
      accepted++;
      if (q_l.size() > 0) begin
        s_left  = q_l.pop_front();
        s_right = q_r.pop_front();
      end else begin
        s_valid = 1'b0;
      end
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    if (!s_valid) begin
      s_left = l; s_right = r; s_valid = 1'b1;
    end else begin
      q_l.push_back(l); q_r.push_back(r);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_bck"}, bck, 0);
    chk({tag, "_lrck"}, lrck, 1);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_ready"}, s_ready, 1);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ur"}, underrun, 0);
  endtask

  // Release reset: first bck rise at the 4th clk, first lrck fall at the 8th.
  task automatic release_chk(input string tag);
    int n, t_bck;
    n = 0; t_bck = -1;
    rst_n = 1'b1;
    have_prev = 0;
    do begin
      step(); n++;
      if (bck && t_bck < 0) t_bck = n;
    end while (lrck !== 1'b0 && n < 40);
    chk({tag, "_first_bck_rise"}, t_bck, 4);
    chk({tag, "_first_lrck_fall"}, n, 8);
  endtask

  // Wait for a frame load, then collect 32 bits on the following bck rises.
  task automatic capture(input logic [31:0] exp_f, input logic [31:0] exp_p,
                         input bit chk_pad, input bit exp_ur, input string tag);
    logic [31:0] f, fp;
    int n, caps, lr_err, fs_x, ur_x, t_fs, t_rise;
    logic ur_seen, pb, pl;
    f = '0; fp = '0; n = 0; caps = 0; lr_err = 0; fs_x = 0; ur_x = 0; t_rise = -1;
    do begin step(); n++; end while (frame_start !== 1'b1 && n < 600);
    chk({tag, "_fs_seen"}, frame_start, 1);
    t_fs = cyc;
    ur_seen = underrun;
    if (have_prev) chk({tag, "_frame_period"}, t_fs - last_fs, 256);
    last_fs = t_fs; have_prev = 1;
    pb = bck; pl = lrck; n = 0;
    while (caps < 32 && n < 400) begin
      step(); n++;
      if (frame_start) fs_x++;
      if (underrun) ur_x++;
      if (lrck && !pl) t_rise = cyc - t_fs;
      if (bck && !pb) begin
        caps++;
        f  = {f[30:0], din};
        fp = {fp[30:0], p_din};
        if (lrck !== ((caps >= 16) && (caps < 32))) lr_err++;
      end
      pb = bck; pl = lrck;
    end
    chk({tag, "_data"}, f, exp_f);
    if (chk_pad) chk({tag, "_pad_data"}, fp, exp_p);
    chk({tag, "_underrun"}, ur_seen, exp_ur);
    chk({tag, "_extra_pulses"}, fs_x + ur_x, 0);
    chk({tag, "_lrck_align"}, lr_err, 0);
    chk({tag, "_lrck_rise_at"}, t_rise, 120);
  endtask

  initial begin
    int base;
    repeat (3) step();
    chk_rst("por");
    chk("por_pad_ready", p_ready, 1);
    release_chk("por");

    // Data path and 12-bit padding.
    offer(16'hA5F0, 16'h1234);
    capture(32'hA5F01234, 32'hABC08000, 1, 0, "A");

    // Starvation: silent frame with an underrun pulse.
    capture(32'h0, 32'h0, 1, 1, "B_underrun");

    // Bypass: valid first asserted in the load clk.
    while (cyc < last_fs + 255) step();
    offer(16'h5A0F, 16'hC3E1);
    capture(32'h5A0FC3E1, 32'h0, 0, 0, "C_bypass");
    chk("C_hold_empty", s_ready, 1);

    // Backpressure: one pair per frame, none lost or duplicated.
    base = accepted;
    for (int k = 1; k <= 4; k++) offer(16'(k), 16'(32'h8000 + k));
    for (int k = 1; k <= 4; k++) begin
      capture({16'(k), 16'(32'h8000 + k)}, 32'h0, 0, 0, "bp");
      chk("bp_accepted", accepted - base, (k < 4) ? k + 1 : 4);
    end
    capture(32'h0, 32'h0, 0, 1, "H_underrun");

    // Reset at pos 20 with a pair waiting in the holding register.
    offer(16'h1111, 16'h2222);
    offer(16'h3333, 16'h4444);
    while (cyc < last_fs + 256 + 154) step();
    chk("I_hold_full", s_ready, 0);
    rst_n = 1'b0;
    #2;
    chk_rst("mid");
    repeat (2) step();
    release_chk("mid");
    capture(32'h0, 32'h0, 1, 1, "post_rst");
    for (int k = 0; k < 3; k++) capture(32'h0, 32'h0, 0, 1, "idle");

`ifdef I2S_TX_TESTGEN_EN
    rst_n = 1'b0;
    test_en = 1'b1;
    repeat (2) step();
    release_chk("tg");
    capture(32'h0000FFFF, 32'h0, 0, 0, "tg0");
    chk("tg_ready_low", s_ready, 0);
    capture(32'h0001FFFE, 32'h0, 0, 0, "tg1");
    test_en = 1'b0;
    capture(32'h0, 32'h0, 0, 1, "tg_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_tx_stereo.md
Name: i2s_tx_stereo

Overview:
- Parametrised I2S (Philips format) stereo transmitter for an external PCM DAC, e.g. PCM5102-class; DAC SCK is tied low.
- Generates BCK and LRCK from the system clock with an exact fractional phase accumulator.
- Serialises one stereo sample pair per frame.
- Samples arrive through a valid/ready port backed by a one-pair holding register; starvation yields a silent frame plus an underrun pulse.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- SAMPLE_HZ, 44100, audio sample rate (LRCK frequency) in Hz.
- DATA_W, 16, sample width per channel; 1 <= DATA_W <= SLOT_W.
- SLOT_W, 16, BCK cycles per channel slot; frame is 2*SLOT_W BCK cycles.
- ACC_W, 25, phase accumulator width; must hold CLK_HZ + INC without overflow.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  stereo pair available.
- s_ready  out  1  holding register can accept a pair.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- bck  out  1  I2S bit clock.
- lrck  out  1  word select; 0 = left, 1 = right.
- din  out  1  serial data to DAC.
- frame_start  out  1  one-clk pulse on each frame load.
- underrun  out  1  one-clk pulse when a frame loads with no data available.

Behaviour:
- Reset (async assert, sync release): bck=0, lrck=1, din=0, s_ready=1, frame_start=0, underrun=0, accumulator=0, holding empty, frame register=0, bit position pos=2*SLOT_W-1.
- Rate generation:
  - INC = 4*SAMPLE_HZ*SLOT_W (two BCK edges per bit).
  - Each clk: if acc+INC >= CLK_HZ then acc <= acc+INC-CLK_HZ and tick=1; else acc <= acc+INC.
  - Long-term tick rate is exactly INC per second.
- Elaboration error if INC > CLK_HZ, DATA_W > SLOT_W, or ACC_W is too small.
- Each tick toggles bck; all outputs are registers.
- Rising tick (bck 0->1): no other state change.
- Falling tick (bck 1->0), same clk: pos <= (pos+1) mod 2*SLOT_W, then:
  - lrck <= (new pos >= SLOT_W).
  - New pos==1 (load): frame register F (2*SLOT_W bits) <= {s_left_src, zero pad to SLOT_W, s_right_src, zero pad to SLOT_W}, samples MSB-first; din <= F MSB; frame_start=1 for this clk.
  - Other new pos values: din <= next F bit, MSB to LSB order.
  - New pos==0: din <= final bit of previous F (right LSB/pad), giving the I2S one-BCK delay after the lrck edge.
- Load source priority:
  - Holding full: holding contents are loaded and holding is emptied.
  - Else, s_valid=1 in the load clk: pair bypasses straight into F; the handshake completes; no underrun.
  - Else: F loads all zeros; underrun=1 for this clk.
- Handshake:
  - s_ready = !holding_full, registered.
  - Accept when s_valid && s_ready.
  - Holding full and loaded in the same clk: s_ready was 0, so no accept that clk; ready rises next clk.
  - s_left/s_right must stay stable while s_valid=1 && s_ready=0.
- Reset mid-frame: all state returns to reset values immediately; the held pair is discarded; no frame_start/underrun pulse during reset.
- The first frame after reset starts at the first falling tick (pos 0, lrck 1->0).

Optional Feature:
- Macro I2S_TX_TESTGEN_EN.
- Defined:
  - Adds input port test_en (1 bit).
  - While test_en=1: each load takes left=cnt, right=~cnt from an internal DATA_W-bit counter (reset 0), then cnt increments by 1 mod 2^DATA_W.
  - s_ready forced 0; holding register untouched; underrun never pulses.
  - test_en=0 restores normal sourcing at the next load.
- Undefined: no test_en port, no counter logic; behaviour exactly as above.

Test Plan:
- Rate check: CLK_HZ=12000000, SAMPLE_HZ=46875, SLOT_W=16 (INC=3000000) -> tick every 4 clk, bck period 8 clk, lrck period 256 clk, high/low 128 clk each, zero drift over 100 frames.
- Data path: DATA_W=16, push L=0xA5F0, R=0x1234 -> din after lrck fall is 1 BCK of the old LSB, then 1010010111110000; after lrck rise, 1 old bit then 0001001000110100; frame_start pulses once.
- Padding: DATA_W=12, SLOT_W=16, L=0xABC, R=0x800 -> wire slots read 0xABC0 and 0x8000.
- Underrun and bypass:
  - s_valid=0 -> frame of all zeros, underrun pulse, lrck/bck uninterrupted.
  - s_valid first asserted in the exact load clk with holding empty -> pair transmitted in that frame, no underrun.
- Backpressure: s_valid held 1 with values 1,2,3... -> one pair accepted per frame, s_ready low between accept and load, no pair lost or duplicated.
- Reset mid-frame at pos=20: outputs return to reset values, holding empties; after release, first lrck fall occurs at the 2nd tick. With I2S_TX_TESTGEN_EN and test_en=1, DATA_W=16: successive frames carry L=0000/R=FFFF, then L=0001/R=FFFE.
